branch_sequencer: RTL and testbench

Program-counter sequencer that drives instruction fetch and resolves branch, call and return control flow. Absolute branch and call targets come from the external branch-target lookup table: the sequencer passes the instruction's 5-bit key out to the table and gets an 8-bit target address back in the same cycle. The block sits between the decoder, which supplies the control strobes, and instruction memory, which is indexed by `pc`. It also owns run/halt sequencing (`start`/`done`) and a run-cycle counter.

---
 rtl/branch_sequencer.sv | 106 ++++++++++
 tb/tb_branch_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_sequencer.sv
// ============================================================================
// Module   : branch_sequencer
// Purpose  : PC sequencer with branch/call/return, run/halt control and
//            a saturating run-cycle counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module branch_sequencer #(
  parameter int              PC_W     = 10,
  parameter logic [PC_W-1:0] START_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            stall,
  input  logic            halt,
  input  logic            branch_en,
  input  logic            take,
  input  logic            call_en,
  input  logic            ret_en,
  input  logic [4:0]      key,
  output logic [4:0]      lut_key,
  input  logic [7:0]      lut_addr,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            done,
  output logic [15:0]     cycle_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [PC_W-1:0] r_pc, w_pc_nxt;
  logic [PC_W-1:0] r_ret_addr, w_ret_addr_nxt;
  logic [15:0]     r_cnt, w_cnt_nxt;
  logic [PC_W-1:0] w_target;
  logic [PC_W-1:0] w_pc_inc;

  assign lut_key  = key;
  // Table addresses are unsigned; the cast zero-extends.
  assign w_target = PC_W'(lut_addr);
  assign w_pc_inc = r_pc + PC_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_pc       <= START_PC;
      r_ret_addr <= START_PC;
      r_cnt      <= 16'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_ret_addr <= w_ret_addr_nxt;
      r_cnt      <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_ret_addr_nxt = r_ret_addr;
    w_cnt_nxt      = r_cnt;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (r_state == S_IDLE) w_pc_nxt = START_PC;
        if (start) begin
          w_state_nxt = S_RUN;
          w_pc_nxt    = START_PC;
          w_cnt_nxt   = 16'd0;
        end
      end
      S_RUN: begin
        // Stalled cycles still count as run time.
        if (r_cnt != 16'hFFFF) w_cnt_nxt = r_cnt + 16'd1;
        if (stall) begin
          w_pc_nxt = r_pc;
        end else if (halt) begin
          w_state_nxt = S_DONE;
        end else if (ret_en) begin
          w_pc_nxt = r_ret_addr;
        end else if (call_en) begin
          w_ret_addr_nxt = w_pc_inc;
          w_pc_nxt       = w_target;
        end else if (branch_en && take) begin
          w_pc_nxt = w_target;
        end else begin
          w_pc_nxt = w_pc_inc;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign pc          = r_pc;
  assign busy        = (r_state == S_RUN);
  assign done        = (r_state == S_DONE);
  assign cycle_count = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_branch_sequencer.sv
// ============================================================================
// Module   : tb_branch_sequencer
// Purpose  : Directed scoreboard bench for branch_sequencer.
// Revision : 1.1
// ============================================================================
`default_nettype none

module tb_branch_sequencer;

    localparam logic [7:0] C_NONE = 8'h00;
    localparam logic [7:0] C_RST  = 8'h80;
    localparam logic [7:0] C_STA  = 8'h40;
    localparam logic [7:0] C_STL  = 8'h20;
    localparam logic [7:0] C_HLT  = 8'h10;
    localparam logic [7:0] C_BR   = 8'h08;
    localparam logic [7:0] C_TK   = 8'h04;
    localparam logic [7:0] C_CAL  = 8'h02;
    localparam logic [7:0] C_RET  = 8'h01;
    localparam int         C_TIMEOUT_NS = 2000000;

    logic        clk = 1'b0;
    logic        reset = 1'b0, start = 1'b0, stall = 1'b0, halt = 1'b0;
    logic        branch_en = 1'b0, take = 1'b0, call_en = 1'b0, ret_en = 1'b0;
    logic [4:0]  key = 5'd0;
    logic [4:0]  lut_key;
    logic [7:0]  lut_addr;
    logic [9:0]  pc;
    logic        busy, done;
    logic [15:0] cycle_count;
    logic        r_sim_done = 1'b0;

    typedef struct {
        logic [9:0]  pc;
        logic        busy;
        logic        done;
        logic [15:0] cnt;
        logic [4:0]  key;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    branch_sequencer #(.PC_W(10), .START_PC(10'd0)) dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall), .halt(halt),
        .branch_en(branch_en), .take(take), .call_en(call_en), .ret_en(ret_en),
        .key(key), .lut_key(lut_key), .lut_addr(lut_addr), .pc(pc),
        .busy(busy), .done(done), .cycle_count(cycle_count)
    );

    // Lookup table, answering from the key the DUT presents.
    always_comb begin
        case (lut_key)
            5'd10:   lut_addr = 8'd168;
            5'd17:   lut_addr = 8'd254;
            5'd3:    lut_addr = 8'd5;
            5'd4:    lut_addr = 8'd20;
            5'd5:    lut_addr = 8'd40;
            5'd6:    lut_addr = 8'd77;
            default: lut_addr = {3'b000, lut_key};
        endcase
    end

    // Drive one cycle of controls and queue the state expected after the edge.
    task automatic cyc(input logic [7:0] ctl, input logic [4:0] k,
                       input logic [9:0] epc, input logic eb, input logic ed,
                       input logic [15:0] ec, input string nm);
        exp_t e;
        @(negedge clk);
        {reset, start, stall, halt, branch_en, take, call_en, ret_en} = ctl;
        key = k;
        e.pc = epc; e.busy = eb; e.done = ed; e.cnt = ec; e.key = k; e.name = nm;
        sb.push_back(e);
    endtask

    task automatic check_reset_state();
        @(posedge clk);
        #2;
        checks++;
        if (pc !== 10'd0 || busy !== 1'b0 || done !== 1'b0 ||
            cycle_count !== 16'd0 || dut.r_ret_addr !== 10'd0)
            $display("FAIL reset_state: pc=%0d busy=%0b done=%0b cnt=%0d ret_addr=%0d",
                     pc, busy, done, cycle_count, dut.r_ret_addr);
        else
            passed++;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (pc !== e.pc || busy !== e.busy || done !== e.done ||
                    cycle_count !== e.cnt || lut_key !== e.key)
                    $display("FAIL %s: got pc=%0d busy=%0b done=%0b cnt=%0d lut_key=%0d, expected pc=%0d busy=%0b done=%0b cnt=%0d lut_key=%0d",
                             e.name, pc, busy, done, cycle_count, lut_key,
                             e.pc, e.busy, e.done, e.cnt, e.key);
                else
                    passed++;
            end
        end
    end

    initial begin : watchdog
        fork
            wait (r_sim_done);
            #(C_TIMEOUT_NS);
        join_any
        disable fork;
        if (!r_sim_done) begin
            $display("FAIL timeout: stimulus did not complete within %0d ns", C_TIMEOUT_NS);
            $finish;
        end
    end

    initial begin : stimulus
        cyc(C_RST, 5'd0, 10'd0, 1'b0, 1'b0, 16'd0, "reset0");
        check_reset_state();
        cyc(C_RST | C_STA, 5'd0, 10'd0, 1'b0, 1'b0, 16'd0, "reset_over_start");
        cyc(C_BR | C_TK | C_CAL, 5'd10, 10'd0, 1'b0, 1'b0, 16'd0, "idle_hold");
        cyc(C_STA, 5'd0, 10'd0, 1'b1, 1'b0, 16'd0, "start");

        // Sequential run with wrap past 1023.
        for (int i = 1; i <= 1030; i++)
            cyc(C_NONE, 5'(i), 10'(i % 1024), 1'b1, 1'b0, 16'(i), "seq");

        cyc(C_HLT, 5'd0, 10'd6, 1'b0, 1'b1, 16'd1031, "halt1");
        cyc(C_NONE, 5'd0, 10'd6, 1'b0, 1'b1, 16'd1031, "done_hold");
        cyc(C_STA, 5'd0, 10'd0, 1'b1, 1'b0, 16'd0, "restart1");
        for (int i = 1; i <= 5; i++)
            cyc(C_NONE, 5'd0, 10'(i), 1'b1, 1'b0, 16'(i), "inc_to5");

        // Branches.
        cyc(C_BR | C_TK, 5'd10, 10'd168, 1'b1, 1'b0, 16'd6, "br_taken");
        cyc(C_BR | C_TK, 5'd3, 10'd5, 1'b1, 1'b0, 16'd7, "br_back5");
        cyc(C_BR, 5'd10, 10'd6, 1'b1, 1'b0, 16'd8, "br_untaken");
        cyc(C_TK, 5'd10, 10'd7, 1'b1, 1'b0, 16'd9, "take_no_br");
        cyc(C_BR | C_TK, 5'd4, 10'd20, 1'b1, 1'b0, 16'd10, "br_to20");

        // Call and return.
        cyc(C_CAL, 5'd17, 10'd254, 1'b1, 1'b0, 16'd11, "call");
        cyc(C_NONE, 5'd0, 10'd255, 1'b1, 1'b0, 16'd12, "inc255");
        cyc(C_NONE, 5'd0, 10'd256, 1'b1, 1'b0, 16'd13, "inc256");
        cyc(C_NONE, 5'd0, 10'd257, 1'b1, 1'b0, 16'd14, "inc257");
        cyc(C_RET, 5'd0, 10'd21, 1'b1, 1'b0, 16'd15, "ret");
        cyc(C_RET | C_CAL, 5'd17, 10'd21, 1'b1, 1'b0, 16'd16, "ret_over_call");
        cyc(C_RET, 5'd0, 10'd21, 1'b1, 1'b0, 16'd17, "ret_addr_kept");
        cyc(C_CAL, 5'd10, 10'd168, 1'b1, 1'b0, 16'd18, "call_a");
        cyc(C_CAL, 5'd17, 10'd254, 1'b1, 1'b0, 16'd19, "call_nested");
        cyc(C_RET, 5'd0, 10'd169, 1'b1, 1'b0, 16'd20, "ret_nested");

        // Stall priority over halt and return.
        cyc(C_STL | C_HLT, 5'd0, 10'd169, 1'b1, 1'b0, 16'd21, "stall_halt1");
        cyc(C_STL | C_HLT, 5'd0, 10'd169, 1'b1, 1'b0, 16'd22, "stall_halt2");
        cyc(C_STL | C_HLT, 5'd0, 10'd169, 1'b1, 1'b0, 16'd23, "stall_halt3");
        cyc(C_STL | C_RET, 5'd0, 10'd169, 1'b1, 1'b0, 16'd24, "stall_ret");
        cyc(C_HLT, 5'd0, 10'd169, 1'b0, 1'b1, 16'd25, "halt_released");
        cyc(C_BR | C_TK, 5'd10, 10'd169, 1'b0, 1'b1, 16'd25, "done_ignores");

        // Halt at 40, start ignored in RUN, restart.
        cyc(C_STA, 5'd0, 10'd0, 1'b1, 1'b0, 16'd0, "restart2");
        cyc(C_BR | C_TK, 5'd5, 10'd40, 1'b1, 1'b0, 16'd1, "br_to40");
        cyc(C_STA, 5'd0, 10'd41, 1'b1, 1'b0, 16'd2, "start_in_run");
        cyc(C_BR | C_TK, 5'd5, 10'd40, 1'b1, 1'b0, 16'd3, "br_to40b");
        cyc(C_HLT, 5'd0, 10'd40, 1'b0, 1'b1, 16'd4, "halt40");
        cyc(C_STA, 5'd0, 10'd0, 1'b1, 1'b0, 16'd0, "restart3");

        // Reset mid-run clears the link address.
        cyc(C_CAL, 5'd6, 10'd77, 1'b1, 1'b0, 16'd1, "call77");
        cyc(C_RST, 5'd0, 10'd0, 1'b0, 1'b0, 16'd0, "reset_mid");
        cyc(C_STA, 5'd0, 10'd0, 1'b1, 1'b0, 16'd0, "start_after_rst");
        cyc(C_RET, 5'd0, 10'd0, 1'b1, 1'b0, 16'd1, "ret_after_rst");

        // Counter saturation while stalled.
        for (int i = 2; i <= 65535; i++)
            cyc(C_STL, 5'd0, 10'd0, 1'b1, 1'b0, 16'(i), "cnt_ramp");
        cyc(C_STL, 5'd0, 10'd0, 1'b1, 1'b0, 16'hFFFF, "cnt_sat1");
        cyc(C_NONE, 5'd0, 10'd1, 1'b1, 1'b0, 16'hFFFF, "cnt_sat2");

        @(negedge clk);
        {reset, start, stall, halt, branch_en, take, call_en, ret_en} = 8'h00;
        @(posedge clk);
        #2;
        r_sim_done = 1'b1;
        if (sb.size() != 0 || passed != checks)
            $display("FAIL summary: %0d/%0d checks passed, %0d pending",
                     passed, checks, sb.size());
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire
